axil_arbiter_2x1: RTL and testbench
===================================

# axil_arbiter_2x1

Two-to-one AXI4-Lite arbiter that shares a single AXI-Lite slave between two masters. Its first use is in front of the `frame` buffer RAM, so the crossbar port and the GPU scanout/draw master can both reach the buffer. Reads and writes are arbitrated independently, with round-robin grant and exactly one transaction in flight per direction. Payload paths are combinational muxes; only grant and state are registered.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- s0_aw*/s0_w*/s0_b*  slave  AW(ADDR_WIDTH+3+2), W(DATA_WIDTH+STRB_WIDTH+2), B(2+2)  master 0 write side
- s0_ar*/s0_r*  slave  AR(ADDR_WIDTH+3+2), R(DATA_WIDTH+2+2)  master 0 read side
- s1_aw*/s1_w*/s1_b*  slave  same widths  master 1 write side
- s1_ar*/s1_r*  slave  same widths  master 1 read side
- m_aw*/m_w*/m_b*  master  same widths  shared-slave write side
- m_ar*/m_r*  master  same widths  shared-slave read side

## Operation
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: the write request for master n is `sn_awvalid`.
  - If exactly one master requests, grant it.
  - If both request, grant the one not equal to `wlast`.
  - On grant: register `wsel`, clear `aw_done`/`w_done`, go to W_ADDR.
- W_ADDR:
  - `m_awvalid = sel_awvalid & !aw_done`
  - `m_wvalid = sel_wvalid & !w_done`
  - `sel_awready`/`sel_wready` are passed through from the slave.
  - Each handshake sets its done flag.
  - Go to W_RESP when both are done; AW and W handshakes in the same cycle count.
- W_RESP: `m_bready = sel_bready`; `sel_bvalid = m_bvalid`; `sel_bresp = m_bresp`. On the B handshake: `wlast <= wsel`, go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Same grant rule using `arvalid` and `rlast`.
  - R_ADDR forwards AR and goes to R_DATA on the AR handshake.
  - R_DATA forwards R and goes to R_IDLE on the R handshake, updating `rlast`.
- Ungranted master (and both masters in an IDLE state): all readies 0, all valids 0. Its `bresp`/`rresp`/`rdata` are driven 0.
- m_* payloads (addr, prot, data, strb) are always muxed from `wsel`/`rsel`; only the valids are gated.
- Read and write directions are fully independent: one read and one write may be in flight at once, from different masters.

## Timing
- Reset values:
  - States W_IDLE/R_IDLE.
  - `wsel = rsel = 0`.
  - `wlast = rlast = 1`, so s0 wins the first tie.
  - All m_*valid, m_*ready, s*_ready and s*_valid outputs are 0.
- Grant latency: a request sampled in IDLE at cycle N is forwarded on m_* at cycle N+1. Arbitration adds one cycle per transaction.
- Back-to-back throughput: the minimum per direction is 3 cycles per transaction with a zero-wait slave (IDLE, ADDR, RESP/DATA).
- A master that lowers awvalid/arvalid before grant is simply not granted; AXI forbids this, and no error is raised.
- Grant is never revoked until the response handshake completes.
- Reset mid-transaction returns both FSMs to IDLE. Any pending slave response is discarded; the system reset covers the slave too.

## Configuration
- `AXIL_ARBITER_FIXED_PRIO_EN`:
  - Defined: s0 always wins ties, `wlast`/`rlast` are not implemented, and s1 can starve.
  - Undefined (default): round-robin as described.

## Structure
- Shared package `axil_pkg`:
  - `axil_resp_t` enum (OKAY = 2'b00, SLVERR = 2'b10).
  - State enums `arb_wstate_t` and `arb_rstate_t`.
- One sub-module, `rr_grant2`:
  - Combinational 2-requester grant from request bits and the last-grant bit.
  - Instantiated once for reads and once for writes.
  - The fixed-priority macro is handled inside it.

## Test plan
- Single write from s0: addr 0x20000010, data 0xABC, strb 0x7. Required: m_aw/m_w carry those values one cycle after request; s0 gets bresp 0; s1 sees no bvalid.
- Simultaneous s0/s1 read requests from reset. Required: order s0, s1, s0, s1 over 4 transactions; each master receives only its own rdata (0x111 vs 0x222 from the model).
- Write with W presented 3 cycles after AW, then AW and W in the same cycle. Required: both complete and exactly one m_awvalid/m_wvalid handshake each.
- Concurrent s0 write and s1 read with a slave adding 5 wait states on B. Required: the read completes without waiting for the write.
- Rst asserted while in W_RESP. Required: next cycle all valids/readies are 0, the FSM is idle, and the following s1 write is granted normally.
- With `AXIL_ARBITER_FIXED_PRIO_EN`: continuous requests from both masters. Required: s0 is granted in 10 of 10 transactions.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the 2:1 arbiter: response codes, arbiter FSM
// state encodings and a small handshake helper.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } arb_wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } arb_rstate_t;

    // A transfer happens on a channel in every cycle where valid and ready are both high.
    function automatic logic axil_hs(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with master/slave modports.
//
// Handshake rule on every channel (AW, W, B, AR, R): the source raises valid
// with its payload and holds both stable until it sees ready high on a rising
// clock edge; that edge is the transfer. The sink may raise ready at any time,
// but valid must never wait on ready.
interface axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/rr_grant2.sv
// Combinational two-requester grant. With AXIL_ARBITER_FIXED_PRIO_EN defined,
// requester 0 always wins a tie and the last-grant input does not exist;
// otherwise a tie goes to the requester that was not granted last.
module rr_grant2 (
    input  logic [1:0] req,
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
    input  logic       last,
`endif
    output logic       gnt_valid,
    output logic       gnt_sel
);

    // Pick a winner among the raised requests.
    always_comb begin
        gnt_valid = |req;
        gnt_sel   = 1'b0;
        case (req)
            2'b10:   gnt_sel = 1'b1;
`ifdef AXIL_ARBITER_FIXED_PRIO_EN
            2'b11:   gnt_sel = 1'b0;
`else
            2'b11:   gnt_sel = ~last;
`endif
            default: gnt_sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/axil_arbiter_2x1.sv
// Two-to-one AXI4-Lite arbiter: two masters (s0, s1) share one slave (m).
// Reads and writes are arbitrated independently, one transaction in flight
// per direction. Payloads are pure muxes on the registered grant; only the
// valids and readies are gated by the FSMs.
// Build option: AXIL_ARBITER_FIXED_PRIO_EN selects fixed priority (s0 wins
// ties, s1 may starve) instead of round-robin.
module axil_arbiter_2x1
    import axil_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    axil_if.slave       s0,
    axil_if.slave       s1,
    axil_if.master      m,
    output arb_wstate_t dbg_wstate,
    output arb_rstate_t dbg_rstate
);

    // ---------------- write direction ----------------
    arb_wstate_t wstate, wstate_nxt;
    logic        wsel;
    logic        aw_done, w_done;
    logic        wgnt_valid, wgnt_sel;
    logic        sel_awvalid, sel_wvalid, sel_bready;
    logic        aw_hs, w_hs, b_hs;
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
    logic        wlast;
`endif

    rr_grant2 u_wgnt (
        .req       ({s1.awvalid, s0.awvalid}),
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
        .last      (wlast),
`endif
        .gnt_valid (wgnt_valid),
        .gnt_sel   (wgnt_sel)
    );

    assign sel_awvalid = wsel ? s1.awvalid : s0.awvalid;
    assign sel_wvalid  = wsel ? s1.wvalid  : s0.wvalid;
    assign sel_bready  = wsel ? s1.bready  : s0.bready;

    assign aw_hs = axil_hs(m.awvalid, m.awready);
    assign w_hs  = axil_hs(m.wvalid, m.wready);
    assign b_hs  = axil_hs(m.bvalid, m.bready);

    assign m.awaddr = wsel ? s1.awaddr : s0.awaddr;
    assign m.awprot = wsel ? s1.awprot : s0.awprot;
    assign m.wdata  = wsel ? s1.wdata  : s0.wdata;
    assign m.wstrb  = wsel ? s1.wstrb  : s0.wstrb;

    // Write state, grant, per-channel done flags and last-grant history.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_IDLE;
            wsel    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
            wlast   <= 1'b1;
`endif
        end else begin
            wstate <= wstate_nxt;
            case (wstate)
                W_IDLE: begin
                    if (wgnt_valid) begin
                        wsel    <= wgnt_sel;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                W_RESP: begin
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
                    if (b_hs) wlast <= wsel;
`endif
                end
                default: ;
            endcase
        end
    end

    // Write next state: AW and W may finish in either order or together.
    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE: if (wgnt_valid) wstate_nxt = W_ADDR;
            W_ADDR: if ((aw_done | aw_hs) & (w_done | w_hs)) wstate_nxt = W_RESP;
            W_RESP: if (b_hs) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Write handshake routing; readies are masked once a channel is done so a
    // master presenting its next AW/W early is not accepted twice.
    always_comb begin
        m.awvalid  = 1'b0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        s0.awready = 1'b0;
        s0.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s0.bresp   = OKAY;
        s1.awready = 1'b0;
        s1.wready  = 1'b0;
        s1.bvalid  = 1'b0;
        s1.bresp   = OKAY;
        case (wstate)
            W_ADDR: begin
                m.awvalid = sel_awvalid & ~aw_done;
                m.wvalid  = sel_wvalid & ~w_done;
                if (wsel) begin
                    s1.awready = m.awready & ~aw_done;
                    s1.wready  = m.wready & ~w_done;
                end else begin
                    s0.awready = m.awready & ~aw_done;
                    s0.wready  = m.wready & ~w_done;
                end
            end
            W_RESP: begin
                m.bready = sel_bready;
                if (wsel) begin
                    s1.bvalid = m.bvalid;
                    s1.bresp  = m.bresp;
                end else begin
                    s0.bvalid = m.bvalid;
                    s0.bresp  = m.bresp;
                end
            end
            default: ;
        endcase
    end

    // ---------------- read direction ----------------
    arb_rstate_t rstate, rstate_nxt;
    logic        rsel;
    logic        rgnt_valid, rgnt_sel;
    logic        sel_arvalid, sel_rready;
    logic        ar_hs, r_hs;
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
    logic        rlast;
`endif

    rr_grant2 u_rgnt (
        .req       ({s1.arvalid, s0.arvalid}),
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
        .last      (rlast),
`endif
        .gnt_valid (rgnt_valid),
        .gnt_sel   (rgnt_sel)
    );

    assign sel_arvalid = rsel ? s1.arvalid : s0.arvalid;
    assign sel_rready  = rsel ? s1.rready  : s0.rready;

    assign ar_hs = axil_hs(m.arvalid, m.arready);
    assign r_hs  = axil_hs(m.rvalid, m.rready);

    assign m.araddr = rsel ? s1.araddr : s0.araddr;
    assign m.arprot = rsel ? s1.arprot : s0.arprot;

    // Read state, grant and last-grant history.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rsel   <= 1'b0;
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
            rlast  <= 1'b1;
`endif
        end else begin
            rstate <= rstate_nxt;
            if (rstate == R_IDLE && rgnt_valid) rsel <= rgnt_sel;
`ifndef AXIL_ARBITER_FIXED_PRIO_EN
            if (rstate == R_DATA && r_hs) rlast <= rsel;
`endif
        end
    end

    // Read next state.
    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE: if (rgnt_valid) rstate_nxt = R_ADDR;
            R_ADDR: if (ar_hs) rstate_nxt = R_DATA;
            R_DATA: if (r_hs) rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Read handshake routing; the ungranted master sees zero data.
    always_comb begin
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        s0.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s0.rdata   = '0;
        s0.rresp   = OKAY;
        s1.arready = 1'b0;
        s1.rvalid  = 1'b0;
        s1.rdata   = '0;
        s1.rresp   = OKAY;
        case (rstate)
            R_ADDR: begin
                m.arvalid = sel_arvalid;
                if (rsel) s1.arready = m.arready;
                else      s0.arready = m.arready;
            end
            R_DATA: begin
                m.rready = sel_rready;
                if (rsel) begin
                    s1.rvalid = m.rvalid;
                    s1.rdata  = m.rdata;
                    s1.rresp  = m.rresp;
                end else begin
                    s0.rvalid = m.rvalid;
                    s0.rdata  = m.rdata;
                    s0.rresp  = m.rresp;
                end
            end
            default: ;
        endcase
    end

    assign dbg_wstate = wstate;
    assign dbg_rstate = rstate;

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Testbench for axil_arbiter_2x1: write-path vector table plus directed
// sequences for read ordering, concurrent read/write, reset in W_RESP and
// the arbitration policy (round-robin or fixed priority).
module tb_axil_arbiter_2x1;
    import axil_pkg::*;

`ifdef AXIL_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam logic [31:0] S0_ADDR = 32'h2000_0010;
    localparam logic [31:0] S0_DATA = 32'h0000_0ABC;
    localparam logic [3:0]  S0_STRB = 4'h7;
    localparam logic [31:0] S1_ADDR = 32'h3000_0020;
    localparam logic [31:0] S1_DATA = 32'h0000_0DEF;
    localparam logic [3:0]  S1_STRB = 4'hF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_if s0_if ();
    axil_if s1_if ();
    axil_if m_if ();
    arb_wstate_t dbg_wstate;
    arb_rstate_t dbg_rstate;

    axil_arbiter_2x1 dut (
        .clk        (clk),
        .rst        (rst),
        .s0         (s0_if),
        .s1         (s1_if),
        .m          (m_if),
        .dbg_wstate (dbg_wstate),
        .dbg_rstate (dbg_rstate)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        s0_if.awaddr = S0_ADDR; s0_if.awprot = 3'b001; s0_if.wdata = S0_DATA; s0_if.wstrb = S0_STRB;
        s1_if.awaddr = S1_ADDR; s1_if.awprot = 3'b010; s1_if.wdata = S1_DATA; s1_if.wstrb = S1_STRB;
        s0_if.araddr = 32'h100; s0_if.arprot = 3'b000;
        s1_if.araddr = 32'h200; s1_if.arprot = 3'b000;
        s0_if.awvalid = 0; s0_if.wvalid = 0; s0_if.bready = 0; s0_if.arvalid = 0; s0_if.rready = 0;
        s1_if.awvalid = 0; s1_if.wvalid = 0; s1_if.bready = 0; s1_if.arvalid = 0; s1_if.rready = 0;
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = OKAY;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = OKAY;
    endtask

    typedef struct {
        logic [1:0]  awv;    // {s1,s0}
        logic [1:0]  wv;
        logic [1:0]  br;
        logic [2:0]  m_in;   // {m_awready, m_wready, m_bvalid}
        logic [1:0]  m_bresp;
        logic [2:0]  e_m;    // {m_awvalid, m_wvalid, m_bready}
        logic [1:0]  e_awr;  // {s1,s0}
        logic [1:0]  e_wr;
        logic [1:0]  e_bv;
        logic [3:0]  e_br;   // {s1_bresp, s0_bresp}
        arb_wstate_t e_st;
        logic        e_sel;
    } wvec_t;

    function automatic wvec_t mkw(input logic [1:0] awv, input logic [1:0] wv, input logic [1:0] br,
                                  input logic [2:0] m_in, input logic [1:0] m_bresp,
                                  input logic [2:0] e_m, input logic [1:0] e_awr, input logic [1:0] e_wr,
                                  input logic [1:0] e_bv, input logic [3:0] e_br,
                                  input arb_wstate_t e_st, input logic e_sel);
        wvec_t v;
        v.awv = awv; v.wv = wv; v.br = br; v.m_in = m_in; v.m_bresp = m_bresp;
        v.e_m = e_m; v.e_awr = e_awr; v.e_wr = e_wr; v.e_bv = e_bv; v.e_br = e_br;
        v.e_st = e_st; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic drive_w(input wvec_t v);
        s0_if.awvalid = v.awv[0]; s1_if.awvalid = v.awv[1];
        s0_if.wvalid  = v.wv[0];  s1_if.wvalid  = v.wv[1];
        s0_if.bready  = v.br[0];  s1_if.bready  = v.br[1];
        {m_if.awready, m_if.wready, m_if.bvalid} = v.m_in;
        m_if.bresp = v.m_bresp;
    endtask

    // ---------------- write vector table ----------------
    task automatic run_write_table();
        wvec_t wtab[16];
        int aw_cnt = 0;
        int w_cnt = 0;
        // idle, s0 single write (W and AW together), then s1 alone with W late
        wtab[0]  = mkw(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_IDLE, 1'b0);
        wtab[1]  = mkw(2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_IDLE, 1'b0);
        wtab[2]  = mkw(2'b01, 2'b01, 2'b00, 3'b110, 2'b00, 3'b110, 2'b01, 2'b01, 2'b00, 4'h0, W_ADDR, 1'b0);
        wtab[3]  = mkw(2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 4'h0, W_RESP, 1'b0);
        wtab[4]  = mkw(2'b00, 2'b00, 2'b01, 3'b001, 2'b00, 3'b001, 2'b00, 2'b00, 2'b01, 4'h0, W_RESP, 1'b0);
        wtab[5]  = mkw(2'b10, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_IDLE, 1'b0);
        wtab[6]  = mkw(2'b10, 2'b00, 2'b00, 3'b110, 2'b00, 3'b100, 2'b10, 2'b10, 2'b00, 4'h0, W_ADDR, 1'b1);
        wtab[7]  = mkw(2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_ADDR, 1'b1);
        wtab[8]  = mkw(2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 4'h0, W_ADDR, 1'b1);
        wtab[9]  = mkw(2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 3'b010, 2'b00, 2'b10, 2'b00, 4'h0, W_ADDR, 1'b1);
        wtab[10] = mkw(2'b00, 2'b00, 2'b10, 3'b001, 2'b10, 3'b001, 2'b00, 2'b00, 2'b10, 4'b1000, W_RESP, 1'b1);
        // tie after an s1 grant goes to s0; s1 then drops its request unserved
        wtab[11] = mkw(2'b11, 2'b11, 2'b00, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_IDLE, 1'b1);
        wtab[12] = mkw(2'b11, 2'b11, 2'b00, 3'b110, 2'b00, 3'b110, 2'b01, 2'b01, 2'b00, 4'h0, W_ADDR, 1'b0);
        wtab[13] = mkw(2'b10, 2'b10, 2'b01, 3'b001, 2'b00, 3'b001, 2'b00, 2'b00, 2'b01, 4'h0, W_RESP, 1'b0);
        wtab[14] = mkw(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_IDLE, 1'b0);
        wtab[15] = mkw(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 4'h0, W_IDLE, 1'b0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive_w(wtab[i]);
            #1;
            chk($sformatf("wvec%0d_ctl", i),
                {m_if.awvalid, m_if.wvalid, m_if.bready, s1_if.awready, s0_if.awready,
                 s1_if.wready, s0_if.wready, s1_if.bvalid, s0_if.bvalid, s1_if.bresp, s0_if.bresp, dbg_wstate},
                {wtab[i].e_m, wtab[i].e_awr, wtab[i].e_wr, wtab[i].e_bv, wtab[i].e_br, wtab[i].e_st});
            chk($sformatf("wvec%0d_addr_data", i), {m_if.awaddr, m_if.wdata},
                wtab[i].e_sel ? {S1_ADDR, S1_DATA} : {S0_ADDR, S0_DATA});
            chk($sformatf("wvec%0d_strb", i), m_if.wstrb, wtab[i].e_sel ? S1_STRB : S0_STRB);
            if (m_if.awvalid && m_if.awready) aw_cnt++;
            if (m_if.wvalid && m_if.wready) w_cnt++;
        end
        chk("wtab_aw_handshakes", aw_cnt, 3);
        chk("wtab_w_handshakes", w_cnt, 3);
    endtask

    // ---------------- read ordering with simultaneous requests ----------------
    task automatic run_read_order();
        logic        r_pend = 1'b0;
        logic [31:0] r_data = '0;
        int          hs_n = 0;
        logic        who;
        logic [0:0]  e;
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(FIXED_PRIO ? 1'b0 : 1'(k % 2));
        s0_if.araddr = 32'h100; s1_if.araddr = 32'h200;
        s0_if.rready = 1'b1;    s1_if.rready = 1'b1;
        for (int cyc = 0; cyc < 40 && hs_n < 4; cyc++) begin
            @(negedge clk);
            s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
            m_if.arready = 1'b1; m_if.rvalid = r_pend; m_if.rdata = r_data; m_if.rresp = OKAY;
            #1;
            if (s0_if.rvalid || s1_if.rvalid) begin
                who = s1_if.rvalid;
                e = exp_q.pop_front();
                chk($sformatf("rd%0d_single_valid", hs_n), s0_if.rvalid & s1_if.rvalid, 1'b0);
                chk($sformatf("rd%0d_order", hs_n), who, e);
                chk($sformatf("rd%0d_data", hs_n), who ? s1_if.rdata : s0_if.rdata, who ? 32'h222 : 32'h111);
                chk($sformatf("rd%0d_other_zero", hs_n), who ? s0_if.rdata : s1_if.rdata, 32'h0);
                chk($sformatf("rd%0d_cycle", hs_n), cyc, 2 + 3 * hs_n);
                hs_n++;
                r_pend = 1'b0;
            end
            if (m_if.arvalid && m_if.arready) begin
                r_pend = 1'b1;
                r_data = (m_if.araddr == 32'h100) ? 32'h111 : 32'h222;
            end
        end
        @(negedge clk);
        idle_inputs();
        chk("rd_all_done", hs_n, 4);
    endtask

    // ---------------- concurrent s0 write / s1 read, B delayed 5 cycles ----------------
    task automatic run_concurrent();
        int   r_cyc = -1;
        int   b_cyc = -1;
        int   b_wait = 0;
        logic aw_seen = 0, w_seen = 0, ar_seen = 0, b_pend = 0, b_started = 0, r_pend = 0;
        s0_if.bready = 1'b1; s1_if.rready = 1'b1;
        for (int cyc = 0; cyc < 30 && (r_cyc < 0 || b_cyc < 0); cyc++) begin
            @(negedge clk);
            s0_if.awvalid = !aw_seen; s0_if.wvalid = !w_seen; s1_if.arvalid = !ar_seen;
            m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
            m_if.bvalid = b_pend && (b_wait == 5); m_if.bresp = OKAY;
            m_if.rvalid = r_pend; m_if.rdata = 32'h222; m_if.rresp = OKAY;
            #1;
            if (m_if.awvalid && m_if.awready) aw_seen = 1'b1;
            if (m_if.wvalid && m_if.wready) w_seen = 1'b1;
            if (m_if.bvalid && m_if.bready) begin
                b_cyc = cyc;
                b_pend = 1'b0;
                chk("cc_s0_bvalid_bresp", {s0_if.bvalid, s0_if.bresp, s1_if.bvalid}, {1'b1, 2'b00, 1'b0});
            end else if (b_pend) begin
                b_wait++;
            end
            if (aw_seen && w_seen && !b_started) begin
                b_pend = 1'b1;
                b_started = 1'b1;
            end
            if (s1_if.rvalid && s1_if.rready) begin
                r_cyc = cyc;
                r_pend = 1'b0;
                chk("cc_s1_rdata", s1_if.rdata, 32'h222);
            end
            if (m_if.arvalid && m_if.arready) begin
                ar_seen = 1'b1;
                r_pend = 1'b1;
            end
        end
        chk("cc_read_cycle", r_cyc, 2);
        chk("cc_write_b_cycle", b_cyc, 7);
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- reset while in W_RESP ----------------
    task automatic run_reset_in_resp();
        @(negedge clk);
        s0_if.awvalid = 1'b1; s0_if.wvalid = 1'b1;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1 chk("rst_seq_idle", dbg_wstate, W_IDLE);
        @(negedge clk);
        #1 chk("rst_seq_addr", dbg_wstate, W_ADDR);
        @(negedge clk);
        s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0; s0_if.bready = 1'b1;
        m_if.bvalid = 1'b1;
        rst = 1'b1;
        #1 chk("rst_seq_resp", {dbg_wstate, s0_if.bvalid}, {W_RESP, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_all_handshakes_low",
            {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
             s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
             s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid}, 15'h0);
        chk("rst_fsms_idle", {dbg_wstate, dbg_rstate}, {W_IDLE, R_IDLE});
        @(negedge clk);
        s1_if.awvalid = 1'b1; s1_if.wvalid = 1'b1;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1 chk("rst_s1_req_not_yet_fwd", m_if.awvalid, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_s1_grant", {m_if.awvalid, m_if.wvalid, s1_if.awready, s1_if.wready, s0_if.awready}, 5'b11110);
        chk("rst_s1_addr", m_if.awaddr, S1_ADDR);
        @(negedge clk);
        s1_if.awvalid = 1'b0; s1_if.wvalid = 1'b0; s1_if.bready = 1'b1;
        m_if.bvalid = 1'b1;
        #1 chk("rst_s1_bvalid", {s1_if.bvalid, s0_if.bvalid}, 2'b10);
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- arbitration policy under continuous write requests ----------------
    task automatic run_policy();
        logic b_pend = 1'b0;
        int   n_aw = 0;
        int   n_b = 0;
        int   s0_wins = 0;
        logic who;
        for (int cyc = 0; cyc < 80 && n_b < 10; cyc++) begin
            @(negedge clk);
            s0_if.awvalid = 1'b1; s0_if.wvalid = 1'b1; s0_if.bready = 1'b1;
            s1_if.awvalid = 1'b1; s1_if.wvalid = 1'b1; s1_if.bready = 1'b1;
            m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.bvalid = b_pend; m_if.bresp = OKAY;
            #1;
            if (m_if.awvalid && m_if.awready) begin
                who = s1_if.awready;
                chk($sformatf("pol%0d_grant", n_aw), who, FIXED_PRIO ? 1'b0 : 1'(n_aw % 2));
                chk($sformatf("pol%0d_addr", n_aw), m_if.awaddr, who ? S1_ADDR : S0_ADDR);
                if (!who) s0_wins++;
                n_aw++;
            end
            if (m_if.bvalid && m_if.bready) begin
                n_b++;
                b_pend = 1'b0;
            end
            if (m_if.wvalid && m_if.wready) b_pend = 1'b1;
        end
        chk("pol_transactions", n_b, 10);
        chk("pol_aw_count", n_aw, 10);
        chk("pol_s0_wins", s0_wins, FIXED_PRIO ? 10 : 5);
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_read_side",
            {m_if.arvalid, m_if.rready, s0_if.arready, s1_if.arready, s0_if.rvalid, s1_if.rvalid, dbg_rstate}, 8'h0);
        chk("reset_write_side",
            {m_if.awvalid, m_if.wvalid, m_if.bready, s0_if.awready, s1_if.awready, s0_if.bvalid, s1_if.bvalid, dbg_wstate}, 9'h0);

        run_write_table();
        run_read_order();
        run_concurrent();
        run_reset_in_resp();
        run_policy();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
